// File: rtl/axil_reg_endpoint_pkg.sv
// Shared AXI-Lite bus payloads, response codes and endpoint FSM states.
package axil_reg_endpoint_pkg;

    localparam int unsigned axil_addr_width_lp = 32;
    localparam int unsigned axil_data_width_lp = 32;
    localparam int unsigned axil_strb_width_lp = axil_data_width_lp / 8;

    localparam logic [1:0] resp_okay_lp   = 2'b00;
    localparam logic [1:0] resp_slverr_lp = 2'b10;

    typedef struct packed {
        logic [axil_addr_width_lp-1:0] awaddr;
        logic [2:0]                    awprot;
        logic                          awvalid;
        logic [axil_data_width_lp-1:0] wdata;
        logic [axil_strb_width_lp-1:0] wstrb;
        logic                          wvalid;
        logic                          bready;
        logic [axil_addr_width_lp-1:0] araddr;
        logic [2:0]                    arprot;
        logic                          arvalid;
        logic                          rready;
    } bsg_axil_mosi_bus_s;

    typedef struct packed {
        logic                          awready;
        logic                          wready;
        logic [1:0]                    bresp;
        logic                          bvalid;
        logic                          arready;
        logic [axil_data_width_lp-1:0] rdata;
        logic [1:0]                    rresp;
        logic                          rvalid;
    } bsg_axil_miso_bus_s;

    localparam int unsigned mosi_bus_width_lp = $bits(bsg_axil_mosi_bus_s);
    localparam int unsigned miso_bus_width_lp = $bits(bsg_axil_miso_bus_s);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        BRESP = 3'd3,
        RRESP = 3'd4
    } state_e;

endpackage

// File: rtl/axil_wr_joiner.sv
// Collects the independent AW and W channels into holding registers and
// drives their readies; a write is complete once both are held.
module axil_wr_joiner #(
    parameter int unsigned  waddr_width_p = 14,
    parameter int unsigned  data_width_p  = 32,
    localparam int unsigned mask_width_lp = data_width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     awvalid_i,
    input  logic [waddr_width_p-1:0] awaddr_i,
    input  logic                     wvalid_i,
    input  logic [data_width_p-1:0]  wdata_i,
    input  logic [mask_width_lp-1:0] wstrb_i,
    input  logic                     idle_next_i,
    input  logic                     clear_i,
    output logic                     awready_o,
    output logic                     wready_o,
    output logic                     aw_pend_c_o,
    output logic                     w_pend_c_o,
    output logic [waddr_width_p-1:0] awaddr_c_o,
    output logic [data_width_p-1:0]  wdata_c_o,
    output logic [mask_width_lp-1:0] wstrb_c_o
);

    logic                     aw_held_q, w_held_q;
    logic                     awready_q, wready_q;
    logic [waddr_width_p-1:0] awaddr_q;
    logic [data_width_p-1:0]  wdata_q;
    logic [mask_width_lp-1:0] wstrb_q;
    logic                     aw_hs_c, w_hs_c;

    assign aw_hs_c = awvalid_i & awready_q;
    assign w_hs_c  = wvalid_i & wready_q;

    // Held-after-this-edge view, including a handshake landing this cycle.
    assign aw_pend_c_o = (aw_held_q | aw_hs_c) & ~clear_i;
    assign w_pend_c_o  = (w_held_q | w_hs_c) & ~clear_i;
    assign awaddr_c_o  = aw_hs_c ? awaddr_i : awaddr_q;
    assign wdata_c_o   = w_hs_c ? wdata_i : wdata_q;
    assign wstrb_c_o   = w_hs_c ? wstrb_i : wstrb_q;

    assign awready_o = awready_q;
    assign wready_o  = wready_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            aw_held_q <= aw_pend_c_o;
            w_held_q  <= w_pend_c_o;
            awready_q <= idle_next_i & ~aw_pend_c_o;
            wready_q  <= idle_next_i & ~w_pend_c_o;
            if (aw_hs_c) awaddr_q <= awaddr_i;
            if (w_hs_c) begin
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end
        end
    end

endmodule

// File: rtl/axil_reg_endpoint.sv
// AXI-Lite slave endpoint: joins AW/W, arbitrates against AR and serialises
// one outstanding register request, returning B/R responses.
module axil_reg_endpoint
    import axil_reg_endpoint_pkg::*;
#(
    parameter int unsigned  addr_width_p      = 16,
    parameter int unsigned  data_width_p      = 32,
    localparam int unsigned reg_addr_width_lp = addr_width_p - 2,
    localparam int unsigned mask_width_lp     = data_width_p / 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  bsg_axil_mosi_bus_s           s_axil_bus_i,
    output bsg_axil_miso_bus_s           s_axil_bus_o,
    output logic                         reg_v_o,
    output logic                         reg_w_o,
    output logic [reg_addr_width_lp-1:0] reg_addr_o,
    output logic [data_width_p-1:0]      reg_data_o,
    output logic [mask_width_lp-1:0]     reg_mask_o,
    input  logic                         reg_ready_i,
    input  logic                         reg_v_i,
    input  logic [data_width_p-1:0]      reg_data_i,
    input  logic                         reg_err_i
);

    state_e                         state_q, state_d;
    logic                           prio_rd_q, prio_rd_d;
    logic                           ar_held_q, ar_held_d;
    logic [reg_addr_width_lp-1:0]   ar_addr_q, ar_addr_d;
    logic                           arready_q, arready_d;
    logic                           reg_v_q, reg_v_d, reg_w_q, reg_w_d;
    logic [reg_addr_width_lp-1:0]   reg_addr_q, reg_addr_d;
    logic [data_width_p-1:0]        reg_data_q, reg_data_d;
    logic [mask_width_lp-1:0]       reg_mask_q, reg_mask_d;
    logic                           bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]                     bresp_q, bresp_d, rresp_q, rresp_d;
    logic [data_width_p-1:0]        rdata_q, rdata_d;

    logic                           awready, wready;
    logic                           aw_pend_c, w_pend_c;
    logic [reg_addr_width_lp-1:0]   awaddr_c, araddr_c;
    logic [data_width_p-1:0]        wdata_c;
    logic [mask_width_lp-1:0]       wstrb_c;
    logic                           ar_hs_c, wr_cand_c, rd_cand_c, pick_wr_c;
    logic                           wr_clear_c, idle_next_c;
    logic                           unused_c;

    assign unused_c = ^{s_axil_bus_i.awaddr[axil_addr_width_lp-1:addr_width_p],
                        s_axil_bus_i.awaddr[1:0], s_axil_bus_i.awprot,
                        s_axil_bus_i.araddr[axil_addr_width_lp-1:addr_width_p],
                        s_axil_bus_i.araddr[1:0], s_axil_bus_i.arprot};

    axil_wr_joiner #(
        .waddr_width_p(reg_addr_width_lp),
        .data_width_p (data_width_p)
    ) u_wr_joiner (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .awvalid_i  (s_axil_bus_i.awvalid),
        .awaddr_i   (s_axil_bus_i.awaddr[addr_width_p-1:2]),
        .wvalid_i   (s_axil_bus_i.wvalid),
        .wdata_i    (s_axil_bus_i.wdata),
        .wstrb_i    (s_axil_bus_i.wstrb),
        .idle_next_i(idle_next_c),
        .clear_i    (wr_clear_c),
        .awready_o  (awready),
        .wready_o   (wready),
        .aw_pend_c_o(aw_pend_c),
        .w_pend_c_o (w_pend_c),
        .awaddr_c_o (awaddr_c),
        .wdata_c_o  (wdata_c),
        .wstrb_c_o  (wstrb_c)
    );

    assign ar_hs_c     = s_axil_bus_i.arvalid & arready_q;
    assign araddr_c    = ar_hs_c ? s_axil_bus_i.araddr[addr_width_p-1:2] : ar_addr_q;
    assign wr_cand_c   = aw_pend_c & w_pend_c;
    assign rd_cand_c   = ar_held_q | ar_hs_c;
    assign pick_wr_c   = wr_cand_c & (~rd_cand_c | ~prio_rd_q);
    assign wr_clear_c  = (state_q == BRESP) & s_axil_bus_i.bready;
    assign idle_next_c = (state_d == IDLE);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        prio_rd_d  = prio_rd_q;
        ar_held_d  = ar_held_q | ar_hs_c;
        ar_addr_d  = ar_hs_c ? s_axil_bus_i.araddr[addr_width_p-1:2] : ar_addr_q;
        reg_v_d    = reg_v_q;
        reg_w_d    = reg_w_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        reg_mask_d = reg_mask_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (wr_cand_c | rd_cand_c) begin
                    state_d   = REQ;
                    reg_v_d   = 1'b1;
                    prio_rd_d = ~prio_rd_q;
                    reg_w_d   = pick_wr_c;
                    if (pick_wr_c) begin
                        reg_addr_d = awaddr_c;
                        reg_data_d = wdata_c;
                        reg_mask_d = wstrb_c;
                    end else begin
                        reg_addr_d = araddr_c;
                        reg_data_d = '0;
                        reg_mask_d = '0;
                    end
                end
            end
            REQ: begin
                if (reg_ready_i) begin
                    reg_v_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (reg_v_i) begin
                    if (reg_w_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = reg_err_i ? resp_slverr_lp : resp_okay_lp;
                        state_d  = BRESP;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = reg_err_i ? resp_slverr_lp : resp_okay_lp;
                        rdata_d  = reg_data_i;
                        state_d  = RRESP;
                    end
                end
            end
            BRESP: begin
                if (s_axil_bus_i.bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RRESP: begin
                if (s_axil_bus_i.rready) begin
                    rvalid_d  = 1'b0;
                    ar_held_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reads wait while a write is partially collected so it cannot starve.
        arready_d = (state_d == IDLE) & ~aw_pend_c & ~w_pend_c & ~ar_held_d;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            prio_rd_q  <= 1'b0;
            ar_held_q  <= 1'b0;
            ar_addr_q  <= '0;
            arready_q  <= 1'b0;
            reg_v_q    <= 1'b0;
            reg_w_q    <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            reg_mask_q <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= resp_okay_lp;
            rvalid_q   <= 1'b0;
            rresp_q    <= resp_okay_lp;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            prio_rd_q  <= prio_rd_d;
            ar_held_q  <= ar_held_d;
            ar_addr_q  <= ar_addr_d;
            arready_q  <= arready_d;
            reg_v_q    <= reg_v_d;
            reg_w_q    <= reg_w_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            reg_mask_q <= reg_mask_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign reg_v_o    = reg_v_q;
    assign reg_w_o    = reg_w_q;
    assign reg_addr_o = reg_addr_q;
    assign reg_data_o = reg_data_q;
    assign reg_mask_o = reg_mask_q;

    always_comb begin
        s_axil_bus_o         = '0;
        s_axil_bus_o.awready = awready;
        s_axil_bus_o.wready  = wready;
        s_axil_bus_o.bresp   = bresp_q;
        s_axil_bus_o.bvalid  = bvalid_q;
        s_axil_bus_o.arready = arready_q;
        s_axil_bus_o.rdata   = rdata_q;
        s_axil_bus_o.rresp   = rresp_q;
        s_axil_bus_o.rvalid  = rvalid_q;
    end

endmodule

// File: tb/tb_axil_reg_endpoint.sv
// Directed bench for axil_reg_endpoint: write joining, read errors,
// arbitration order, backpressure and asynchronous reset.
module tb_axil_reg_endpoint;
    import axil_reg_endpoint_pkg::*;

    logic               clk = 1'b0;
    logic               reset_i;
    bsg_axil_mosi_bus_s mosi;
    bsg_axil_miso_bus_s miso;
    logic               reg_v_o, reg_w_o;
    logic [13:0]        reg_addr_o;
    logic [31:0]        reg_data_o;
    logic [3:0]         reg_mask_o;
    logic               reg_ready_i, reg_v_i, reg_err_i;
    logic [31:0]        reg_data_i;

    int   checks   = 0;
    int   failures = 0;
    int   mon_errs = 0;
    logic stale_ok = 1'b0;

    always #5 clk = ~clk;

    axil_reg_endpoint dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .s_axil_bus_i(mosi),
        .s_axil_bus_o(miso),
        .reg_v_o     (reg_v_o),
        .reg_w_o     (reg_w_o),
        .reg_addr_o  (reg_addr_o),
        .reg_data_o  (reg_data_o),
        .reg_mask_o  (reg_mask_o),
        .reg_ready_i (reg_ready_i),
        .reg_v_i     (reg_v_i),
        .reg_data_i  (reg_data_i),
        .reg_err_i   (reg_err_i)
    );

    // A response pulse outside WAIT is a bench error unless deliberately stale.
    always @(negedge clk)
        if (reset_i && reg_v_i && !stale_ok && dut.state_q != WAIT) mon_errs++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur(input int which);
        if (which == 0) return reg_v_o;
        if (which == 1) return miso.bvalid;
        return miso.rvalid;
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (!cur(which) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        assert (cur(which)) else begin
            failures++;
            $error("FAIL %s observed=timeout expected=valid", tag);
        end
    endtask

    task automatic chk_req(input string tag, input logic w, input logic [13:0] addr,
                           input logic [31:0] data, input logic [3:0] mask);
        wait_for(0, tag);
        chk({tag, "_w"}, 64'(reg_w_o), 64'(w));
        chk({tag, "_addr"}, 64'(reg_addr_o), 64'(addr));
        chk({tag, "_data"}, 64'(reg_data_o), 64'(data));
        chk({tag, "_mask"}, 64'(reg_mask_o), 64'(mask));
    endtask

    task automatic do_reg(input logic err, input logic [31:0] data);
        reg_ready_i = 1'b1;
        tick();
        reg_ready_i = 1'b0;
        reg_v_i     = 1'b1;
        reg_err_i   = err;
        reg_data_i  = data;
        tick();
        reg_v_i     = 1'b0;
        reg_err_i   = 1'b0;
    endtask

    task automatic finish_b(input string tag, input logic [1:0] resp);
        wait_for(1, tag);
        chk({tag, "_bresp"}, 64'(miso.bresp), 64'(resp));
        mosi.bready = 1'b1;
        tick();
        mosi.bready = 1'b0;
        chk({tag, "_bvalid_clr"}, 64'(miso.bvalid), 64'd0);
    endtask

    task automatic finish_r(input string tag, input logic [1:0] resp, input logic [31:0] data);
        wait_for(2, tag);
        chk({tag, "_rresp"}, 64'(miso.rresp), 64'(resp));
        chk({tag, "_rdata"}, 64'(miso.rdata), 64'(data));
        mosi.rready = 1'b1;
        tick();
        mosi.rready = 1'b0;
        chk({tag, "_rvalid_clr"}, 64'(miso.rvalid), 64'd0);
    endtask

    task automatic do_reset();
        #2 reset_i = 1'b0;
        @(posedge clk);
        #1 reset_i = 1'b1;
        tick();
    endtask

    // AW, W and AR all presented in one cycle; wr_first gives expected order.
    task automatic arb_round(input string tag, input logic [31:0] aw, input logic [31:0] ar,
                             input logic [31:0] data, input logic wr_first);
        logic [31:0] a = aw;
        logic [31:0] r = ar;
        mosi.awvalid = 1'b1; mosi.awaddr = aw;
        mosi.wvalid  = 1'b1; mosi.wdata  = data; mosi.wstrb = 4'hF;
        mosi.arvalid = 1'b1; mosi.araddr = ar;
        tick();
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b0; mosi.arvalid = 1'b0;
        chk({tag, "_arready_low"}, 64'(miso.arready), 64'd0);
        if (wr_first) begin
            chk_req({tag, "_1st_wr"}, 1'b1, a[15:2], data, 4'hF);
            do_reg(1'b0, 32'h0);
            finish_b({tag, "_1st"}, 2'b00);
            chk_req({tag, "_2nd_rd"}, 1'b0, r[15:2], 32'h0, 4'h0);
            do_reg(1'b0, ~data);
            finish_r({tag, "_2nd"}, 2'b00, ~data);
        end else begin
            chk_req({tag, "_1st_rd"}, 1'b0, r[15:2], 32'h0, 4'h0);
            do_reg(1'b0, ~data);
            finish_r({tag, "_1st"}, 2'b00, ~data);
            chk_req({tag, "_2nd_wr"}, 1'b1, a[15:2], data, 4'hF);
            do_reg(1'b0, 32'h0);
            finish_b({tag, "_2nd"}, 2'b00);
        end
    endtask

    initial begin
        mosi        = '0;
        reg_ready_i = 1'b0;
        reg_v_i     = 1'b0;
        reg_err_i   = 1'b0;
        reg_data_i  = 32'h0;
        reset_i     = 1'b1;
        #2 reset_i  = 1'b0;
        tick();
        tick();
        chk("rst_awready", 64'(miso.awready), 64'd0);
        chk("rst_wready", 64'(miso.wready), 64'd0);
        chk("rst_arready", 64'(miso.arready), 64'd0);
        chk("rst_bvalid", 64'(miso.bvalid), 64'd0);
        chk("rst_rvalid", 64'(miso.rvalid), 64'd0);
        chk("rst_reg_v", 64'(reg_v_o), 64'd0);
        chk("rst_rdata", 64'(miso.rdata), 64'd0);
        reset_i = 1'b1;
        tick();
        chk("idle_awready", 64'(miso.awready), 64'd1);
        chk("idle_wready", 64'(miso.wready), 64'd1);
        chk("idle_arready", 64'(miso.arready), 64'd1);

        // AW first, W three cycles later.
        mosi.awvalid = 1'b1; mosi.awaddr = 32'h0000_0010;
        tick();
        mosi.awvalid = 1'b0;
        chk("t1_awready_drop", 64'(miso.awready), 64'd0);
        chk("t1_wready_held", 64'(miso.wready), 64'd1);
        chk("t1_arready_blocked", 64'(miso.arready), 64'd0);
        chk("t1_no_req_yet", 64'(reg_v_o), 64'd0);
        tick();
        tick();
        mosi.wvalid = 1'b1; mosi.wdata = 32'hDEAD_BEEF; mosi.wstrb = 4'hF;
        tick();
        mosi.wvalid = 1'b0;
        chk("t1_wready_drop", 64'(miso.wready), 64'd0);
        chk_req("t1_req", 1'b1, 14'h004, 32'hDEAD_BEEF, 4'hF);
        do_reg(1'b0, 32'h0);
        finish_b("t1", 2'b00);
        chk("t1_awready_back", 64'(miso.awready), 64'd1);

        // W first, AW two cycles later.
        mosi.wvalid = 1'b1; mosi.wdata = 32'h1111_1111; mosi.wstrb = 4'h3;
        tick();
        mosi.wvalid = 1'b0;
        chk("t2_wready_drop", 64'(miso.wready), 64'd0);
        chk("t2_awready_held", 64'(miso.awready), 64'd1);
        tick();
        mosi.awvalid = 1'b1; mosi.awaddr = 32'h0000_0020;
        tick();
        mosi.awvalid = 1'b0;
        chk("t2_awready_drop", 64'(miso.awready), 64'd0);
        chk_req("t2_req", 1'b1, 14'h008, 32'h1111_1111, 4'h3);
        do_reg(1'b0, 32'h0);
        finish_b("t2", 2'b00);

        // Simultaneous AW+W, unaligned with upper bits set, zero strobes, error.
        mosi.awvalid = 1'b1; mosi.awaddr = 32'hABCD_0107;
        mosi.wvalid  = 1'b1; mosi.wdata  = 32'h2222_2222; mosi.wstrb = 4'h0;
        tick();
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
        chk_req("t2s_req", 1'b1, 14'h041, 32'h2222_2222, 4'h0);
        do_reg(1'b1, 32'h0);
        wait_for(1, "t2s_bvalid");
        for (int i = 0; i < 10; i++) begin
            chk("bp_bvalid", 64'(miso.bvalid), 64'd1);
            chk("bp_bresp", 64'(miso.bresp), 64'd2);
            chk("bp_awready", 64'(miso.awready), 64'd0);
            chk("bp_wready", 64'(miso.wready), 64'd0);
            tick();
        end
        finish_b("t2s", 2'b10);

        // Read with register-side stall and error response.
        mosi.arvalid = 1'b1; mosi.araddr = 32'h0000_0FFC;
        tick();
        mosi.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_reg_v_stall", 64'(reg_v_o), 64'd1);
            chk("t3_addr_stall", 64'(reg_addr_o), 64'h3FF);
            tick();
        end
        chk("t3_reg_w", 64'(reg_w_o), 64'd0);
        chk("t3_mask", 64'(reg_mask_o), 64'd0);
        do_reg(1'b1, 32'hCAFE_F00D);
        for (int i = 0; i < 10; i++) begin
            chk("bp_rvalid", 64'(miso.rvalid), 64'd1);
            chk("bp_rdata", 64'(miso.rdata), 64'hCAFE_F00D);
            chk("bp_rresp", 64'(miso.rresp), 64'd2);
            chk("bp_arready", 64'(miso.arready), 64'd0);
            chk("bp_awready_r", 64'(miso.awready), 64'd0);
            tick();
        end
        finish_r("t3", 2'b10, 32'hCAFE_F00D);
        chk("t3_arready_back", 64'(miso.arready), 64'd1);

        // Minimum read latency.
        reg_ready_i  = 1'b1;
        mosi.arvalid = 1'b1; mosi.araddr = 32'h0000_0044;
        tick();
        mosi.arvalid = 1'b0;
        chk("lat_reg_v_c1", 64'(reg_v_o), 64'd1);
        chk("lat_addr", 64'(reg_addr_o), 64'h011);
        tick();
        chk("lat_reg_v_c2", 64'(reg_v_o), 64'd0);
        chk("lat_rvalid_c2", 64'(miso.rvalid), 64'd0);
        reg_ready_i = 1'b0;
        reg_v_i     = 1'b1;
        reg_data_i  = 32'h0BAD_F00D;
        tick();
        reg_v_i = 1'b0;
        chk("lat_rvalid_c3", 64'(miso.rvalid), 64'd1);
        finish_r("lat", 2'b00, 32'h0BAD_F00D);

        // Asynchronous reset while waiting for a register response.
        mosi.arvalid = 1'b1; mosi.araddr = 32'h0000_0008;
        tick();
        mosi.arvalid = 1'b0;
        wait_for(0, "rw_req");
        reg_ready_i = 1'b1;
        tick();
        reg_ready_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        chk("rw_awready", 64'(miso.awready), 64'd0);
        chk("rw_arready", 64'(miso.arready), 64'd0);
        chk("rw_bresp", 64'(miso.bresp), 64'd0);
        chk("rw_rdata", 64'(miso.rdata), 64'd0);
        chk("rw_reg_v", 64'(reg_v_o), 64'd0);
        @(posedge clk);
        #1 reset_i = 1'b1;
        tick();
        chk("rw_arready_back", 64'(miso.arready), 64'd1);
        stale_ok   = 1'b1;
        reg_v_i    = 1'b1;
        reg_data_i = 32'hFFFF_FFFF;
        tick();
        reg_v_i  = 1'b0;
        stale_ok = 1'b0;
        chk("stale_rvalid", 64'(miso.rvalid), 64'd0);
        chk("stale_bvalid", 64'(miso.bvalid), 64'd0);
        chk("stale_reg_v", 64'(reg_v_o), 64'd0);
        mosi.arvalid = 1'b1; mosi.araddr = 32'h0000_000C;
        tick();
        mosi.arvalid = 1'b0;
        chk_req("fresh_req", 1'b0, 14'h003, 32'h0, 4'h0);
        do_reg(1'b0, 32'h1234_5678);
        finish_r("fresh", 2'b00, 32'h1234_5678);

        // Arbitration from reset priority, then with read priority.
        do_reset();
        arb_round("arb1", 32'h0000_0040, 32'h0000_0080, 32'hA0A0_0001, 1'b1);
        arb_round("arb2", 32'h0000_0100, 32'h0000_0204, 32'hA0A0_0002, 1'b1);
        mosi.awvalid = 1'b1; mosi.awaddr = 32'h0000_0200;
        mosi.wvalid  = 1'b1; mosi.wdata  = 32'h0000_0055; mosi.wstrb = 4'hF;
        tick();
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
        chk_req("solo_req", 1'b1, 14'h080, 32'h0000_0055, 4'hF);
        do_reg(1'b0, 32'h0);
        finish_b("solo", 2'b00);
        arb_round("arb3", 32'h0000_0300, 32'h0000_0304, 32'hA0A0_0003, 1'b0);

        chk("reg_v_i_outside_wait", 64'(mon_errs), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_reg_endpoint.md
Name: axil_reg_endpoint

Overview:
AXI-Lite slave endpoint for one master slot of the host AXI-Lite demux; one instance per slot. Joins the independent AW/W channels, serialises reads and writes into a single-outstanding register request/response interface, and returns B/R responses. Sits between one demux master port and a slot's register file or mailbox.

Parameters:
addr_width_p, 16, byte-offset bits decoded inside the slot window; upper AXI address bits are ignored
data_width_p, 32, AXI-Lite data width; fixed at 32, other values are illegal
reg_addr_width_lp, addr_width_p-2, word address width on the register interface

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous reset, active-low (asserted at 0)
s_axil_bus_i  in  bsg_axil_mosi_bus_width(1)  packed AXI-Lite master-to-slave bus from the demux slot
s_axil_bus_o  out  bsg_axil_miso_bus_width(1)  packed AXI-Lite slave-to-master bus to the demux slot
reg_v_o  out  1  register request valid
reg_w_o  out  1  1=write, 0=read
reg_addr_o  out  reg_addr_width_lp  word address = axaddr[addr_width_p-1:2]
reg_data_o  out  32  write data
reg_mask_o  out  4  write byte strobes; 4'h0 on reads
reg_ready_i  in  1  request accepted when reg_v_o & reg_ready_i
reg_v_i  in  1  response valid, one cycle per request
reg_data_i  in  32  read data; ignored for writes
reg_err_i  in  1  response error; maps to SLVERR (2'b10)

Behaviour:
- Reset (reset_i=0, async): state IDLE; awready, wready, arready, bvalid, rvalid, reg_v_o all 0; bresp, rresp 2'b00; rdata 32'h0; aw/w captured flags 0; prio flag = write.
- All outputs registered; no combinational path from any input to any output.
- States: IDLE, REQ, WAIT, BRESP, RRESP.
- AW/W capture in IDLE: awready=1 while no AW held; wready=1 while no W held. Each is captured independently into holding registers on its handshake; order is free; both in the same cycle is legal.
- AR capture in IDLE: arready=1 only while neither AW nor W is held. This prevents a partially collected write from starving.
- Arbitration in IDLE, when a complete write (AW and W held) and an arvalid are presentable together: alternate using a one-bit prio flag, flipped after each serviced op. With only one candidate, it wins.
- Winning an op: drop all readies and enter REQ. reg_v_o=1 with addr/data/mask/w held stable until reg_ready_i=1. Then reg_v_o=0 and enter WAIT.
- reg_v_i while not in WAIT is ignored. Any assertion there is a bench error flagged by assertion.
- WAIT to BRESP (write) on reg_v_i: bvalid=1, bresp = reg_err_i ? 2'b10 : 2'b00.
- WAIT to RRESP (read) on reg_v_i: rvalid=1, rdata=reg_data_i, rresp as for bresp.
- BRESP/RRESP: hold valid and payload until bready/rready. On handshake: clear valid, clear captured flags, return to IDLE. The next AW/W/AR can be accepted the cycle after.
- Minimum latency, read, with reg_ready_i and reg_v_i tied 1: AR handshake at cycle 0, reg_v_o at 1, response captured at 2, rvalid at 3.
- Address low bits [1:0] ignored (unaligned accesses treated as aligned). wstrb=0 is forwarded as-is.
- Reset mid-operation: all state discarded immediately. A request in flight on the register side is abandoned, and its response is ignored after reset.

Decomposition:
- Shared package/header: bsg_axil_bus_s struct and the mosi/miso width macros (existing); AXI response constants OKAY=2'b00, SLVERR=2'b10; FSM state enum.
- Sub-module axil_wr_joiner: AW/W holding registers, captured flags and the ready generation. The top level holds the FSM and the arbiter.

Test Plan:
- Write, AW before W: AW addr 0x0010 at t0, W data 0xDEADBEEF strb 0xF at t3 -> one request {w=1, addr=0x004, data=0xDEADBEEF, mask=0xF}; bresp=00 after reg_v_i.
- Write, W before AW plus simultaneous: W at t0 with AW at t2, then AW+W both at one cycle -> exactly one request per pair, with correct pairing; awready/wready each deassert after its own capture.
- Read with error: AR 0x0FFC, reg_ready_i held 0 for 5 cycles, then reg_v_i with reg_err_i=1 -> reg_addr_o=0x3FF stable 5 cycles; rresp=10, rdata = reg_data_i.
- Arbitration fairness: AR and a complete write pending together, repeated 4 times -> service order W,R,W,R starting from reset prio; no starvation.
- Backpressure: bready/rready held 0 for 10 cycles -> bvalid/rvalid and payload stable; no new readies asserted until the handshake.
- Async reset in WAIT: assert reset_i=0 between clock edges -> all valids/readies drop 0 immediately; after release, a fresh read returns correct data and stale reg_v_i pulses are ignored.
